// File: rtl/desc_fetch_ctrl.sv
// Descriptor fetch controller: issues one 128-byte read per descriptor line,
// reissues failed lines up to MAX_RETRY times, and assembles the returned halves.
module desc_fetch_ctrl #(
   parameter int NUM_LINES = 2,
   parameter int MAX_RETRY = 3
) (
   input  logic                      clock,
   input  logic                      rstn_in,
   input  logic                      enabled_in,
   input  logic                      start_in,
   input  logic [63:0]               base_address,
   input  logic                      cmd_ready_in,
   output logic                      cmd_valid_out,
   output logic [63:0]               cmd_address_out,
   output logic [7:0]                cmd_tag_out,
   input  logic                      rsp_valid_in,
   input  logic [7:0]                rsp_tag_in,
   input  logic                      rsp_ok_in,
   input  logic                      data_valid_in,
   input  logic [7:0]                data_tag_in,
   input  logic                      data_half_in,
   input  logic [511:0]              data_in,
   output logic                      desc_valid_out,
   output logic [NUM_LINES*1024-1:0] desc_data_out,
   input  logic                      desc_ack_in,
   output logic                      busy_out,
   output logic                      error_out
);

   localparam int DW = NUM_LINES * 1024;
   localparam int NH = NUM_LINES * 2;
   localparam int RW = $clog2(MAX_RETRY + 2);

   typedef enum logic [1:0] {IDLE, FETCH, DONE, ERROR} state_t;

   state_t               state, state_next;
   logic                 rst_q;
   logic [NUM_LINES-1:0] pending, done_map, issue_mask, ok_mask, fail_mask;
   logic [RW-1:0]        retry_cnt;
   logic [63:0]          base_q;
   logic [7:0]           issue_idx;
   logic                 issue, start_fire, rsp_hit, data_hit, abort;
   logic [511:0]         halves [NH];

   // Reset asserts asynchronously but releases one edge later, so no state
   // register sees the same edge that ends reset.
   always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) rst_q <= 1'b0;
      else          rst_q <= 1'b1;
   end

   always_comb begin
      // NOTE: every variable gets a default before any branch; otherwise a path that skips the assignment infers a latch.
      start_fire = start_in && enabled_in && (state == IDLE || state == ERROR);
      rsp_hit    = rsp_valid_in && (state == FETCH) && (rsp_tag_in < 8'(NUM_LINES));
      data_hit   = data_valid_in && (state == FETCH) && (data_tag_in < 8'(NUM_LINES));
      ok_mask    = '0;
      fail_mask  = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (rsp_hit && rsp_tag_in == 8'(i)) begin
            ok_mask[i]   = rsp_ok_in;
            fail_mask[i] = !rsp_ok_in;
         end
      end
      abort      = (|fail_mask) && (retry_cnt == RW'(MAX_RETRY));
      // Scan downward so the lowest pending line wins.
      issue_mask = '0;
      issue_idx  = '0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (pending[i]) begin
            issue_mask    = '0;
            issue_mask[i] = 1'b1;
            issue_idx     = 8'(i);
         end
      end
      issue = (state == FETCH) && (|pending) && cmd_ready_in && enabled_in && !abort;
   end

   always_ff @(posedge clock or negedge rstn_in) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
      if (!rstn_in)   state <= IDLE;
      else if (rst_q) state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_fire) state_next = FETCH;
         FETCH:   if (abort) state_next = ERROR;
                  else if (&done_map) state_next = DONE;
         DONE:    if (desc_ack_in) state_next = IDLE;
         ERROR:   if (start_fire) state_next = FETCH;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_out       = (state != IDLE);
      desc_valid_out = (state == DONE);
      error_out      = (state == ERROR);
   end

   always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) begin
         pending         <= '0;
         done_map        <= '0;
         retry_cnt       <= '0;
         base_q          <= '0;
         cmd_valid_out   <= 1'b0;
         cmd_address_out <= '0;
         cmd_tag_out     <= '0;
      end else if (rst_q) begin
         cmd_valid_out <= issue;
         if (issue) begin
            cmd_address_out <= base_q + {49'd0, issue_idx, 7'd0};
            cmd_tag_out     <= issue_idx;
         end
         if (start_fire) begin
            base_q    <= base_address;
            pending   <= '1;
            done_map  <= '0;
            retry_cnt <= '0;
         end else if (state == FETCH) begin
            // A failed line is re-marked after the issue clear, so it waits a cycle.
            pending  <= (pending & ~(issue ? issue_mask : '0)) | fail_mask;
            done_map <= done_map | ok_mask;
            if ((|fail_mask) && !abort) retry_cnt <= retry_cnt + RW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge rstn_in) begin
      // NOTE: the line buffer is reset too, because desc_data_out must read as zero after reset.
      if (!rstn_in) begin
         for (int k = 0; k < NH; k++) halves[k] <= '0;
      end else if (rst_q) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            if (data_hit && data_tag_in == 8'(i)) halves[2*i + (data_half_in ? 1 : 0)] <= data_in;
         end
      end
   end

   always_comb begin
      desc_data_out = '0;
      for (int k = 0; k < NH; k++) desc_data_out[DW-1-512*k -: 512] = halves[k];
   end

endmodule

// File: doc/desc_fetch_ctrl.md
DESC_FETCH_CTRL -- requirements
Module: desc_fetch_ctrl

Interface
REQ-001 SHALL take parameter NUM_LINES, default 2, meaning number of 128-byte cachelines per descriptor (legal 1..8).
REQ-002 SHALL take parameter MAX_RETRY, default 3, meaning number of failed-response reissues allowed per descriptor before abort.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port rstn_in  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enabled_in  in  1  AFU enable; gates start and command issue.
REQ-006 SHALL have port start_in  in  1  single-cycle fetch request.
REQ-007 SHALL have port base_address  in  64  byte address of line 0; line i at base_address + 128*i.
REQ-008 SHALL have port cmd_ready_in  in  1  command buffer not almost-full.
REQ-009 SHALL have ports cmd_valid_out  out  1, cmd_address_out  out  64 and cmd_tag_out  out  8: READ_CL_NA request, size 128, tag = line index.
REQ-010 SHALL have ports rsp_valid_in  in  1, rsp_tag_in  in  8 and rsp_ok_in  in  1: response; ok=1 DONE, ok=0 failed.
REQ-011 SHALL have ports data_valid_in  in  1, data_tag_in  in  8, data_half_in  in  1 and data_in  in  512: read-data half-line.
REQ-012 SHALL have ports desc_valid_out  out  1, desc_data_out  out  NUM_LINES*1024 and desc_ack_in  in  1: assembled descriptor; line 0 half 0 in the MSBs.
REQ-013 SHALL have ports busy_out  out  1 and error_out  out  1: high while not IDLE, and sticky abort flag respectively.

Function
REQ-014 SHALL implement states IDLE, FETCH, DONE and ERROR.
REQ-015 SHALL move IDLE->FETCH on start_in && enabled_in, latching base_address, setting the pending bitmap to all ones and clearing the done bitmap and the retry count; start_in SHALL be ignored outside IDLE.
REQ-016 SHALL, in FETCH, when pending is nonzero, cmd_ready_in=1 and enabled_in=1, register one command next cycle for the lowest set pending bit and clear that bit; otherwise cmd_valid_out SHALL be 0.
REQ-017 SHALL issue at most one command per cycle, giving a back-to-back issue rate of 1/cycle, with up to NUM_LINES commands outstanding.
REQ-018 SHALL, on rsp_valid_in with tag < NUM_LINES in FETCH: if ok=1, set done[tag]; if ok=0, set pending[tag] and increment the retry count.
REQ-019 SHALL, when a failed response would make the retry count exceed MAX_RETRY, move to ERROR, set error_out and stop issuing.
REQ-020 SHALL ignore responses and data with tag >= NUM_LINES, and SHALL ignore all responses and data in IDLE, DONE and ERROR.
REQ-021 SHALL, on data_valid_in with tag < NUM_LINES in FETCH, write data_in into half data_half_in of line tag; a later write to the same half SHALL overwrite it (retry data).
REQ-022 SHALL move FETCH->DONE in the cycle after done becomes all ones; desc_valid_out SHALL be 1 throughout DONE, and desc_data_out SHALL be stable while desc_valid_out=1.
REQ-023 SHALL move DONE->IDLE on desc_ack_in, with desc_valid_out deasserting the following cycle.
REQ-024 SHALL leave ERROR only via reset or start_in (ERROR->FETCH, clearing error_out).
REQ-025 SHALL, when enabled_in drops in FETCH, hold off new issues while still accepting responses and data; issue SHALL resume when enabled_in returns.
REQ-026 SHALL give a failed response for a line priority over a same-cycle issue decision, so the reissue occurs no earlier than the next cycle.
REQ-027 SHALL, with NUM_LINES=1, behave as a single-line fetch with identical timing.

Reset
REQ-028 SHALL, on rstn_in low at any time including mid-fetch, immediately return to IDLE with cmd_valid_out=0, desc_valid_out=0, busy_out=0, error_out=0, bitmaps 0 and retry count 0; desc_data_out SHALL be 0 after reset.
REQ-029 SHALL deassert reset synchronously through one register stage before any state update.

Verification
REQ-030 SHALL be verified as: NUM_LINES=2, base 0x1000, cmd_ready=1, start -> commands at 0x1000 tag 0 then 0x1080 tag 1 on consecutive cycles; both ok with data -> desc_valid_out asserted with the four halves in order.
REQ-031 SHALL be verified as: tag 1 response ok=0 once -> reissue of 0x1080 tag 1; ok -> descriptor valid, error_out=0.
REQ-032 SHALL be verified as: MAX_RETRY=3, four consecutive failures on tag 0 -> ERROR, error_out=1, no further commands; a subsequent start -> refetch from line 0.
REQ-033 SHALL be verified as: cmd_ready_in=0 for 5 cycles after start -> no command issued; ready=1 -> issue resumes at tag 0.
REQ-034 SHALL be verified as: rstn_in low with tag 0 outstanding -> all outputs 0 next edge; a late response after reset -> ignored, state stays IDLE.
REQ-035 SHALL be verified as: response and data with tag 5 and NUM_LINES=2 -> no bitmap or data change.
